// File: rtl/fifo_uart_pkg.sv
// Shared types and sizing helpers for the FIFO-drain UART transmitter.
package fifo_uart_pkg;

  // Frame sequencer states; 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  // Ceiling log2, same definition as the FIFO uses for its pointers.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Default frame geometry and the counter widths it implies.
  localparam int DEF_WIDTH        = 8;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_BAUD_W       = clog2(DEF_CLKS_PER_BIT);
  localparam int DEF_BIT_W        = clog2(DEF_WIDTH + 1);

endpackage

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and serializes each word as
// start bit, WIDTH data bits LSB-first, optional even parity, one stop bit.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_pop,
  output logic             tx,
  output logic             busy,
  output logic [15:0]      frames_sent
);

  localparam int BAUD_W = clog2(CLKS_PER_BIT);
  localparam int BIT_W  = clog2(WIDTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic                par_q, par_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [15:0]         frames_q, frames_d;
  logic                tx_q, tx_d;
  logic                baud_end;
  logic                pop;

  // Next-state logic: sequencing, baud/bit counting and the shift register.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    frames_d = frames_q;
    pop      = 1'b0;
    baud_end = (baud_q == BAUD_LAST);

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        // Pops only ever come from here, so at most one per frame.
        if (en && !fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Registered FIFO data is valid now, one cycle after the pop.
        shreg_d = fifo_dout;
        par_d   = ^fifo_dout;
        bit_d   = '0;
        baud_d  = '0;
        state_d = ST_START;
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d   = '0;
          frames_d = frames_q + 16'd1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Line level is decoded from the upcoming state so tx leaves a flop.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; everything clears asynchronously, tx idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      frames_q <= 16'd0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      frames_q <= frames_d;
      tx_q     <= tx_d;
    end
  end

  assign fifo_pop    = pop;
  assign tx          = tx_q;
  assign busy        = (state_q != ST_IDLE);
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (lane 0 without parity, lane 1 with
// parity), each fed by a small FIFO model, checked every cycle against a
// frame-waveform model plus directed literal expectations.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        en [2];
  logic        fifo_empty [2];
  logic [7:0]  fifo_dout [2] = '{8'h00, 8'h00};
  logic        fifo_pop [2];
  logic        tx [2];
  logic        busy [2];
  logic [15:0] frames [2];

  logic [7:0]  mem [2][64];
  int          wr [2] = '{0, 0};
  int          rd [2] = '{0, 0};
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  bit          mon_on = 1'b0;
  int          force_cnt = 0;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .fifo_empty(fifo_empty[0]),
    .fifo_dout(fifo_dout[0]), .fifo_pop(fifo_pop[0]), .tx(tx[0]),
    .busy(busy[0]), .frames_sent(frames[0]));

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .fifo_empty(fifo_empty[1]),
    .fifo_dout(fifo_dout[1]), .fifo_pop(fifo_pop[1]), .tx(tx[1]),
    .busy(busy[1]), .frames_sent(frames[1]));

  // FIFO models: registered read data appears the cycle after a pop.
  assign fifo_empty[0] = (wr[0] == rd[0]);
  assign fifo_empty[1] = (wr[1] == rd[1]);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int l = 0; l < 2; l++) begin
      if (fifo_pop[l]) begin
        fifo_dout[l] <= mem[l][rd[l]];
        rd[l]        <= rd[l] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is a list of line levels, each lasting C cycles,
  // preceded by the pop cycle and the fetch cycle (both line high).
  int          m_ph [2] = '{-1, -1};
  logic [10:0] m_fb [2] = '{11'd0, 11'd0};
  logic [15:0] m_fm [2] = '{16'd0, 16'd0};
  int          m_seen = 0;
  logic        e_tx, e_busy, e_pop;
  logic [7:0]  m_w;

  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      if (mon_on) begin
        for (int l = 0; l < 2; l++) begin
          if (l == 0 && m_seen != force_cnt) begin
            m_seen  = force_cnt;
            m_fm[0] = 16'hFFFF;
          end
          if (!rst_n) begin
            m_ph[l] = -1;
            m_fm[l] = 16'd0;
          end
          e_pop  = 1'b0;
          e_tx   = 1'b1;
          e_busy = (m_ph[l] >= 1);
          if (m_ph[l] < 0) e_pop = rst_n && en[l] && (wr[l] != rd[l]);
          else if (m_ph[l] >= 2) e_tx = m_fb[l][(m_ph[l] - 2) / C];
          check($sformatf("l%0d tx cyc%0d", l, cyc), tx[l], e_tx);
          check($sformatf("l%0d busy cyc%0d", l, cyc), busy[l], e_busy);
          check($sformatf("l%0d pop cyc%0d", l, cyc), fifo_pop[l], e_pop);
          check($sformatf("l%0d frames cyc%0d", l, cyc), frames[l], m_fm[l]);
          if (rst_n) begin
            if (m_ph[l] < 0) begin
              if (e_pop) begin
                m_w = mem[l][rd[l]];
                m_fb[l] = '0;
                for (int i = 0; i < 8; i++) m_fb[l][1 + i] = m_w[i];
                if (l == 1) begin
                  m_fb[l][9]  = ^m_w;
                  m_fb[l][10] = 1'b1;
                end else begin
                  m_fb[l][9] = 1'b1;
                end
                m_ph[l] = 1;
              end
            end else if (m_ph[l] == (10 + l) * C + 1) begin
              m_ph[l] = -1;
              m_fm[l] = m_fm[l] + 16'd1;
            end else begin
              m_ph[l] = m_ph[l] + 1;
            end
          end
        end
      end
    end
  end

  task automatic push(input int l, input logic [7:0] d);
    mem[l][wr[l]] = d;
    wr[l] = wr[l] + 1;
  endtask

  // Entered just after a negedge; returns at negedge+3 of the pop cycle.
  task automatic wait_pop(input int l, output int t, output bit found);
    found = 1'b0;
    t = -1;
    for (int n = 0; n < 300 && !found; n++) begin
      #3;
      if (fifo_pop[l]) begin
        found = 1'b1;
        t = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!found) check($sformatf("l%0d pop wait", l), 0, 1);
  endtask

  // Captures one frame (one level per bit); returns just after the negedge
  // of the cycle following the stop bit.
  task automatic capture(input int l, output logic [10:0] v, output int t_pop);
    int nb, glitch, extra;
    bit found;
    nb = 10 + l;
    v = '0;
    glitch = 0;
    extra = 0;
    wait_pop(l, t_pop, found);
    if (!found) return;
    @(negedge clk); #3;
    if (fifo_pop[l]) extra++;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < C; c++) begin
        @(negedge clk); #3;
        if (c == 0) v[k] = tx[l];
        else if (tx[l] !== v[k]) glitch++;
        if (fifo_pop[l]) extra++;
      end
    end
    @(negedge clk);
    check($sformatf("l%0d bit hold", l), glitch, 0);
    check($sformatf("l%0d pop inside frame", l), extra, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [10:0] fv;
  int t1, t2, t3, cnt;
  bit fnd, done;

  initial begin : stimulus
    en[0] = 1'b0;
    en[1] = 1'b0;

    // 1. asynchronous reset, visible before any clock edge
    #3 rst_n = 1'b0;
    #1;
    for (int l = 0; l < 2; l++) begin
      check($sformatf("rst l%0d tx", l), tx[l], 1'b1);
      check($sformatf("rst l%0d busy", l), busy[l], 1'b0);
      check($sformatf("rst l%0d pop", l), fifo_pop[l], 1'b0);
      check($sformatf("rst l%0d frames", l), frames[l], 16'h0000);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;

    // 2. single frame 0xA5
    push(0, 8'hA5);
    en[0] = 1'b1;
    capture(0, fv, t1);
    check("a5 frame", fv, 11'h34A);
    #3;
    check("a5 frames_sent", frames[0], 16'd1);
    check("a5 busy after", busy[0], 1'b0);
    check("a5 fifo drained", wr[0] - rd[0], 0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk); #3;
      if (fifo_pop[0]) cnt++;
    end
    check("a5 no pop when empty", cnt, 0);

    // 3. back-to-back 0x00, 0xFF, 0x3C
    @(negedge clk);
    do_reset();
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    capture(0, fv, t1);
    check("b2b frame0", fv, 11'h200);
    capture(0, fv, t2);
    check("b2b frame1", fv, 11'h3FE);
    capture(0, fv, t3);
    check("b2b frame2", fv, 11'h278);
    check("b2b spacing01", t2 - t1, 42);
    check("b2b spacing12", t3 - t2, 42);
    cnt = 0;
    repeat (20) begin
      #3;
      if (fifo_pop[0]) cnt++;
      @(negedge clk);
    end
    check("b2b no 4th pop", cnt, 0);
    check("b2b frames_sent", frames[0], 16'd3);

    // 4. parity lane: 0x07 -> parity 1, 0x03 -> parity 0
    en[0] = 1'b0;
    do_reset();
    push(1, 8'h07);
    push(1, 8'h03);
    en[1] = 1'b1;
    capture(1, fv, t1);
    check("par 07 frame", fv, 11'h60E);
    capture(1, fv, t2);
    check("par 03 frame", fv, 11'h406);
    check("par spacing", t2 - t1, 46);
    #3;
    check("par frames_sent", frames[1], 16'd2);
    en[1] = 1'b0;

    // 5. en dropped mid-frame
    @(negedge clk);
    do_reset();
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    en[0] = 1'b1;
    wait_pop(0, t1, fnd);
    repeat (10) @(negedge clk);
    en[0] = 1'b0;
    cnt = 0;
    repeat (60) begin
      @(negedge clk); #3;
      if (fifo_pop[0]) cnt++;
    end
    check("en0 no pop", cnt, 0);
    check("en0 frame finished", frames[0], 16'd1);
    check("en0 idle", busy[0], 1'b0);
    check("en0 words left", wr[0] - rd[0], 2);
    @(negedge clk);
    en[0] = 1'b1;
    #3;
    check("en1 pop resumes", fifo_pop[0], 1'b1);
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk); #3;
      if (wr[0] == rd[0] && !busy[0]) done = 1'b1;
    end
    check("en1 drain done", done, 1'b1);
    check("en1 frames_sent", frames[0], 16'd3);

    // 6. reset during data bit 3, then a clean frame, then counter wrap
    @(negedge clk);
    do_reset();
    push(0, 8'h52);
    wait_pop(0, t1, fnd);
    repeat (19) @(negedge clk);
    #3;
    check("midrst bit3 low", tx[0], 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst tx", tx[0], 1'b1);
    check("midrst busy", busy[0], 1'b0);
    check("midrst pop", fifo_pop[0], 1'b0);
    check("midrst frames", frames[0], 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 8'h6B);
    capture(0, fv, t1);
    check("post-rst frame", fv, 11'h2D6);
    check("post-rst frames", frames[0], 16'd1);

    force dut0.frames_q = 16'hFFFF;
    force_cnt++;
    #2;
    release dut0.frames_q;
    #1;
    check("wrap preset", frames[0], 16'hFFFF);
    @(negedge clk);
    push(0, 8'h81);
    capture(0, fv, t1);
    check("wrap frame", fv, 11'h302);
    #3;
    check("wrap frames_sent", frames[0], 16'h0000);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
